// File: rtl/fpga_adder_pkg.sv
// rtl/fpga_adder_pkg.sv - shared types and constants for the calculator sequencer
`timescale 1ns/1ps

package fpga_adder_pkg;

  // Operand and result width of the calculator datapath
  localparam int DATA_WIDTH = 4;

  // op_code encodings
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Sequencer states; the encoding is driven directly onto state_leds
  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_EXEC = 2'b10,
    S_SHOW = 2'b11
  } state_e;

endpackage

// File: rtl/calc_sequencer_adder4.sv
// rtl/calc_sequencer_adder4.sv - 4-bit adder with carry-in and carry-out
`timescale 1ns/1ps

module Adder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  // Plain binary add; bit 4 of the 5-bit total is the carry-out
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - push-button add/subtract calculator sequencer
`timescale 1ns/1ps

module calc_sequencer
  import fpga_adder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sw,
  input  logic                  op_code,
  input  logic                  chain,
  input  logic                  btn,
  output logic [DATA_WIDTH-1:0] a_val,
  output logic [DATA_WIDTH-1:0] b_val,
  output logic [DATA_WIDTH-1:0] sum_val,
  output logic                  carry,
  output logic                  overflow,
  output logic                  op_light,
  output logic [1:0]            state_leds,
  output logic                  result_valid,
  output logic [7:0]            op_count
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button front end
  logic             sync1_q, sync2_q;
  logic             db_level_q, db_level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // Sequencer registers
  state_e                state_q;
  logic [DATA_WIDTH-1:0] a_val_q, b_val_q, sum_val_q;
  logic                  carry_q, overflow_q, op_light_q, result_valid_q;
  logic [7:0]            op_count_q;

  // Datapath
  logic                  sub_op;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_cout;
  logic                  add_ovf;

  // Two-flop synchronizer for the asynchronous push button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce, press detection and post-reset arming.
  // The counter runs while the synchronized level disagrees with the
  // debounced level and restarts on any agreement. While unarmed and idle
  // low, the same counter measures a full stable-low window; only then can
  // a rising edge count as a press, so a button held through reset release
  // must be let go and pressed again.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    armed_d    = armed_q;
    press_d    = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == CNT_LAST) begin
        db_level_d = sync2_q;
        press_d    = sync2_q & armed_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end else if (!armed_q && !db_level_q) begin
      if (db_cnt_q == CNT_LAST) begin
        armed_d = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers; press_q is a one-cycle registered pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      armed_q    <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      armed_q    <= armed_d;
      press_q    <= press_d;
    end
  end

  // Subtraction is A + ~B + 1; carry-out of 1 then means no borrow
  assign sub_op = (op_light_q == OP_SUB);
  assign b_eff  = b_val_q ^ {DATA_WIDTH{sub_op}};

  Adder4 u_adder4 (
    .a_i    (a_val_q),
    .b_i    (b_eff),
    .cin_i  (sub_op),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Signed overflow: both addend signs equal and the result sign differs
  assign add_ovf = (a_val_q[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                   (add_sum[DATA_WIDTH-1] != a_val_q[DATA_WIDTH-1]);

  // Operand capture / execute / show sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_A;
      a_val_q        <= '0;
      b_val_q        <= '0;
      sum_val_q      <= '0;
      carry_q        <= 1'b0;
      overflow_q     <= 1'b0;
      op_light_q     <= 1'b0;
      result_valid_q <= 1'b0;
      op_count_q     <= 8'd0;
    end else begin
      case (state_q)
        S_A: begin
          if (press_q) begin
            a_val_q <= sw;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (press_q) begin
            b_val_q    <= sw;
            op_light_q <= op_code;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Single cycle; any press arriving now is dropped
          sum_val_q      <= add_sum;
          carry_q        <= add_cout;
          overflow_q     <= add_ovf;
          op_count_q     <= op_count_q + 8'd1;
          result_valid_q <= 1'b1;
          state_q        <= S_SHOW;
        end
        S_SHOW: begin
          if (press_q) begin
            result_valid_q <= 1'b0;
            if (chain) begin
              a_val_q <= sum_val_q;
              state_q <= S_B;
            end else begin
              state_q <= S_A;
            end
          end
        end
        default: state_q <= S_A;
      endcase
    end
  end

  assign a_val        = a_val_q;
  assign b_val        = b_val_q;
  assign sum_val      = sum_val_q;
  assign carry        = carry_q;
  assign overflow     = overflow_q;
  assign op_light     = op_light_q;
  assign state_leds   = state_q;
  assign result_valid = result_valid_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer
`timescale 1ns/1ps

module tb_calc_sequencer;
  import fpga_adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       op_code = 1'b0;
  logic       chain = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] a_val, b_val, sum_val;
  logic       carry, overflow, op_light, result_valid;
  logic [1:0] state_leds;
  logic [7:0] op_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       c;
    logic       v;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic       reuse;
    logic       exit_chain;
    logic [3:0] exp_a;
    logic [3:0] exp_sum;
    logic       exp_c;
    logic       exp_v;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[7];
  logic [7:0] model_cnt = 8'd0;
  logic       rv_prev = 1'b0;

  calc_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .op_code      (op_code),
    .chain        (chain),
    .btn          (btn),
    .a_val        (a_val),
    .b_val        (b_val),
    .sum_val      (sum_val),
    .carry        (carry),
    .overflow     (overflow),
    .op_light     (op_light),
    .state_leds   (state_leds),
    .result_valid (result_valid),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent arithmetic reference using integer math
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic op);
    exp_t e;
    int sa, sb_i, r;
    sa   = (a >= 8) ? int'(a) - 16 : int'(a);
    sb_i = (b >= 8) ? int'(b) - 16 : int'(b);
    r    = op ? sa - sb_i : sa + sb_i;
    e.a  = a;
    e.b  = b;
    e.sum = op ? 4'((int'(a) - int'(b)) & 15) : 4'((int'(a) + int'(b)) & 15);
    e.c   = op ? (a >= b) : ((int'(a) + int'(b)) > 15);
    e.v   = (r > 7) || (r < -8);
    e.cnt = 8'd0;
    return e;
  endfunction

  task automatic press();
    @(negedge clk) btn = 1'b1;
    repeat (8) @(negedge clk);
    btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // One complete operation; expected result is queued before the B press
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic op,
                       input logic reuse, input logic exit_chain, input exp_t e_in);
    exp_t e;
    e = e_in;
    if (!reuse) begin
      sw = a;
      press();
    end
    check("in_state_b", 32'(state_leds), 32'(S_B));
    sw = b;
    op_code = op;
    model_cnt = model_cnt + 8'd1;
    e.cnt = model_cnt;
    sb.push_back(e);
    press();
    sw = 4'($urandom);
    op_code = 1'($urandom);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("show_state", 32'(state_leds), 32'(S_SHOW));
    chain = exit_chain;
    press();
    chain = 1'($urandom);
    check("after_show", 32'(state_leds), exit_chain ? 32'(S_B) : 32'(S_A));
    check("rv_cleared", 32'(result_valid), 32'd0);
  endtask

  // Scoreboard consumer: compare on each rising edge of result_valid
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rv_prev = 1'b0;
      end else begin
        if (result_valid && !rv_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 32'd0, 32'd1);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("res_a", 32'(a_val), 32'(e.a));
            check("res_b", 32'(b_val), 32'(e.b));
            check("res_sum", 32'(sum_val), 32'(e.sum));
            check("res_carry", 32'(carry), 32'(e.c));
            check("res_ovf", 32'(overflow), 32'(e.v));
            check("res_count", 32'(op_count), 32'(e.cnt));
          end
        end
        rv_prev = result_valid;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state_leds), 32'(S_A));
    check({tag, "_a"}, 32'(a_val), 32'd0);
    check({tag, "_b"}, 32'(b_val), 32'd0);
    check({tag, "_sum"}, 32'(sum_val), 32'd0);
    check({tag, "_cv"}, {30'd0, carry, overflow}, 32'd0);
    check({tag, "_opl"}, 32'(op_light), 32'd0);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check({tag, "_cnt"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic hit;

    vecs[0] = '{4'd5,  4'd3, OP_ADD, 1'b0, 1'b0, 4'd5,  4'd8,  1'b0, 1'b1};
    vecs[1] = '{4'd3,  4'd5, OP_SUB, 1'b0, 1'b0, 4'd3,  4'd14, 1'b0, 1'b0};
    vecs[2] = '{4'd7,  4'd7, OP_SUB, 1'b0, 1'b0, 4'd7,  4'd0,  1'b1, 1'b0};
    vecs[3] = '{4'd5,  4'd3, OP_ADD, 1'b0, 1'b1, 4'd5,  4'd8,  1'b0, 1'b1};
    vecs[4] = '{4'd0,  4'd1, OP_SUB, 1'b1, 1'b0, 4'd8,  4'd7,  1'b1, 1'b1};
    vecs[5] = '{4'd15, 4'd1, OP_ADD, 1'b0, 1'b0, 4'd15, 4'd0,  1'b1, 1'b0};
    vecs[6] = '{4'd8,  4'd8, OP_ADD, 1'b0, 1'b0, 4'd8,  4'd0,  1'b1, 1'b1};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      e.a = vecs[i].exp_a;
      e.b = vecs[i].b;
      e.sum = vecs[i].exp_sum;
      e.c = vecs[i].exp_c;
      e.v = vecs[i].exp_v;
      e.cnt = 8'd0;
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].reuse, vecs[i].exit_chain, e);
    end

    // Short glitch must not be accepted as a press
    sw = 4'd9;
    @(negedge clk) btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_state", 32'(state_leds), 32'(S_A));

    // Button held across reset release produces no press until re-pressed
    btn = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 8'd0;
    repeat (30) @(negedge clk);
    check("held_no_press", 32'(state_leds), 32'(S_A));
    btn = 1'b0;
    repeat (20) @(negedge clk);
    sw = 4'd6;
    press();
    check("repress_state", 32'(state_leds), 32'(S_B));
    check("repress_a", 32'(a_val), 32'd6);

    // Reset asserted during the execute cycle discards the operation
    sw = 4'd2;
    op_code = OP_ADD;
    @(negedge clk) btn = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (state_leds == S_EXEC) begin
        rst_n = 1'b0;
        hit = 1'b1;
        break;
      end
    end
    check("exec_reached", 32'(hit), 32'd1);
    #1;
    check_all_zero("exec_rst");
    btn = 1'b0;
    model_cnt = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_cnt", 32'(op_count), 32'd0);

    // 256 random operations wrap the operation counter back to zero
    for (int n = 0; n < 256; n++) begin
      logic [3:0] ra, rb;
      logic       rop;
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      rop = 1'($urandom);
      do_op(ra, rb, rop, 1'b0, 1'b0, model(ra, rb, rop));
    end
    check("wrap_count", 32'(op_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 250000 and set the consecutive stable cycles needed to accept a button level.
REQ-003 Ports SHALL be:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw  in  4  operand switches
- op_code  in  1  0 = add, 1 = subtract
- chain  in  1  1 = next entry reuses the last result as operand A
- btn  in  1  raw, asynchronous, active-high push button
- a_val  out  4  latched operand A
- b_val  out  4  latched operand B
- sum_val  out  4  latched result
- carry  out  1  adder carry-out of the last operation
- overflow  out  1  signed overflow of the last operation
- op_light  out  1  latched op_code of the current operation
- state_leds  out  2  current FSM state encoding
- result_valid  out  1  high while in S_SHOW
- op_count  out  8  count of completed operations

Function
REQ-004 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-005 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any shorter glitch restarts the count.
REQ-006 A press SHALL be a one-cycle pulse on each 0->1 edge of the debounced level.
REQ-007 FSM states SHALL be S_A=00, S_B=01, S_EXEC=10, S_SHOW=11, driven on state_leds.
REQ-008 In S_A, a press SHALL latch sw into a_val and move to S_B.
REQ-009 In S_B, a press SHALL latch sw into b_val and op_code into op_light, then move to S_EXEC.
REQ-010 S_EXEC SHALL last exactly one cycle and capture the following, then move to S_SHOW:
- sum_val = a_val + (b_val XOR {4{op}}) + op, mod 16
- carry = bit-4 carry-out
- overflow = two's-complement signed overflow
- op_count incremented by 1, wrapping 255->0
REQ-011 In S_SHOW with chain=1 sampled at the press, a press SHALL copy sum_val into a_val and move to S_B.
REQ-012 In S_SHOW with chain=0 sampled at the press, a press SHALL move to S_A.
REQ-013 For REQ-011 and REQ-012, all result registers SHALL hold until the next S_EXEC.
REQ-014 Presses in S_EXEC SHALL be ignored.
REQ-015 sw, op_code and chain changes outside their capture cycle SHALL have no effect.
REQ-016 For subtraction, carry=1 SHALL mean no borrow.
REQ-017 All outputs SHALL be registered; the result is visible one cycle after the S_B press edge plus the S_EXEC cycle.

Reset
REQ-018 rst_n low SHALL immediately and asynchronously force:
- state S_A
- a_val, b_val, sum_val, carry, overflow, op_light = 0
- op_count = 0, result_valid = 0
- synchronizer flops, debounced level and debounce counter = 0
REQ-019 Reset asserted mid-operation, including during S_EXEC, SHALL discard that operation with no op_count increment.
REQ-020 A button held high across reset release SHALL NOT generate a press until the button is released and pressed again.

Structure
REQ-021 Shared package fpga_adder_pkg SHALL hold:
- the state enumeration
- DATA_WIDTH = 4
- the op_code encodings
REQ-022 The arithmetic SHALL use one instance of the team's existing Adder4 sub-module.
REQ-023 Synchronizer and debounce logic SHALL be inline.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 The bench SHALL cover these directed scenarios:
- A=5, B=3, add -> sum_val=8, carry=0, overflow=1, op_count=1
- A=3, B=5, sub -> sum_val=14, carry=0, overflow=0
- A=7, B=7, sub -> sum_val=0, carry=1, overflow=0
- Chain: 5+3=8 with chain=1, then B=1 sub -> a_val=8, sum_val=7, carry=1, overflow=1
- btn glitch of 3 cycles -> no state change
- Reset pulse in S_EXEC -> state S_A, all outputs 0, op_count=0
- 256 completed operations -> op_count wraps to 0
